// File: rtl/mouse_packet_decoder.sv
// PS/2 mouse packet decoder: collects 3-byte movement packets, accumulates clamped
// absolute cursor position and button levels, and resynchronises on bad framing or timeout.
module mouse_packet_decoder #(
  parameter int unsigned X_MAX          = 1023,
  parameter int unsigned Y_MAX          = 767,
  parameter int unsigned X_INIT         = 512,
  parameter int unsigned Y_INIT         = 384,
  parameter int unsigned TIMEOUT_CYCLES = 65000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] mouse_xpos,
  output logic [11:0] mouse_ypos,
  output logic        left_mouse,
  output logic        right_mouse,
  output logic        packet_valid,
  output logic        sync_error
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [12:0] XMax13 = 13'(X_MAX);
  localparam logic [12:0] YMax13 = 13'(Y_MAX);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {WaitB0, WaitB1, WaitB2, Apply} state_e;

  state_e          r_state;
  logic [7:0]      r_status;
  logic [7:0]      r_dx;
  logic [7:0]      r_dy;
  logic [CntW-1:0] r_cnt;
  logic [11:0]     r_xpos;
  logic [11:0]     r_ypos;
  logic            r_left;
  logic            r_right;
  logic            r_packet_valid;
  logic            r_sync_error;

  logic [12:0] w_dx;
  logic [12:0] w_dy;
  logic [12:0] w_sum_x;
  logic [12:0] w_sum_y;
  logic [11:0] w_next_x;
  logic [11:0] w_next_y;
  logic        w_timeout;
  logic        w_unused_status;

  // Overflowed axes contribute nothing; deltas are sign-extended 9-bit values.
  assign w_dx = r_status[6] ? 13'd0 : {{5{r_status[4]}}, r_dx};
  assign w_dy = r_status[7] ? 13'd0 : {{5{r_status[5]}}, r_dy};

  // PS/2 +Y is upward while screen Y grows downward, hence the subtraction.
  assign w_sum_x = {1'b0, r_xpos} + w_dx;
  assign w_sum_y = {1'b0, r_ypos} - w_dy;

  assign w_next_x = w_sum_x[12]       ? 12'd0        :
                    (w_sum_x > XMax13) ? XMax13[11:0] : w_sum_x[11:0];
  assign w_next_y = w_sum_y[12]       ? 12'd0        :
                    (w_sum_y > YMax13) ? YMax13[11:0] : w_sum_y[11:0];

  assign w_timeout       = (r_cnt == CntLast);
  assign w_unused_status = ^r_status[3:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= WaitB0;
      r_status       <= 8'd0;
      r_dx           <= 8'd0;
      r_dy           <= 8'd0;
      r_cnt          <= '0;
      r_xpos         <= 12'(X_INIT);
      r_ypos         <= 12'(Y_INIT);
      r_left         <= 1'b0;
      r_right        <= 1'b0;
      r_packet_valid <= 1'b0;
      r_sync_error   <= 1'b0;
    end else begin
      r_packet_valid <= 1'b0;
      r_sync_error   <= 1'b0;
      unique case (r_state)
        WaitB0: begin
          r_cnt <= '0;
          if (rx_valid) begin
            if (rx_data[3]) begin
              r_status <= rx_data;
              r_state  <= WaitB1;
            end else begin
              r_sync_error <= 1'b1;
            end
          end
        end
        WaitB1: begin
          if (rx_valid) begin
            r_dx    <= rx_data;
            r_cnt   <= '0;
            r_state <= WaitB2;
          end else if (w_timeout) begin
            r_cnt        <= '0;
            r_state      <= WaitB0;
            r_sync_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WaitB2: begin
          if (rx_valid) begin
            r_dy    <= rx_data;
            r_cnt   <= '0;
            r_state <= Apply;
          end else if (w_timeout) begin
            r_cnt        <= '0;
            r_state      <= WaitB0;
            r_sync_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        Apply: begin
          r_xpos         <= w_next_x;
          r_ypos         <= w_next_y;
          r_left         <= r_status[0];
          r_right        <= r_status[1];
          r_packet_valid <= 1'b1;
          r_cnt          <= '0;
          r_state        <= WaitB0;
        end
        default: r_state <= WaitB0;
      endcase
    end
  end

  assign mouse_xpos   = r_xpos;
  assign mouse_ypos   = r_ypos;
  assign left_mouse   = r_left;
  assign right_mouse  = r_right;
  assign packet_valid = r_packet_valid;
  assign sync_error   = r_sync_error;

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Scoreboard bench for mouse_packet_decoder: directed packets push expected events,
// a negedge monitor pops and compares on every packet_valid / sync_error pulse.
module tb_mouse_packet_decoder;

  localparam int unsigned TimeoutCycles = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        left_mouse;
  logic        right_mouse;
  logic        packet_valid;
  logic        sync_error;

  mouse_packet_decoder #(
    .X_MAX          (1023),
    .Y_MAX          (767),
    .X_INIT         (512),
    .Y_INIT         (384),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .mouse_xpos   (mouse_xpos),
    .mouse_ypos   (mouse_ypos),
    .left_mouse   (left_mouse),
    .right_mouse  (right_mouse),
    .packet_valid (packet_valid),
    .sync_error   (sync_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [11:0] x;
    logic [11:0] y;
    logic        l;
    logic        r;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] m_x;
  logic [11:0] m_y;
  logic        m_l;
  logic        m_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_pkt(input logic [11:0] x, input logic [11:0] y, input logic l,
                          input logic r);
    q.push_back('{err: 1'b0, x: x, y: y, l: l, r: r});
    m_x = x;
    m_y = y;
    m_l = l;
    m_r = r;
  endtask

  // A sync error leaves every output as it was.
  task automatic push_err();
    q.push_back('{err: 1'b1, x: m_x, y: m_y, l: m_l, r: m_r});
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    check(name, q.size(), 0);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    q.delete();
    m_x = 12'd512;
    m_y = 12'd384;
    m_l = 1'b0;
    m_r = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst && (packet_valid || sync_error)) begin
      if (packet_valid && sync_error) check("pv_se_exclusive", 1, 0);
      if (q.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        mon_e = q.pop_front();
        check("event_is_sync_error", sync_error, mon_e.err);
        check("xpos", mouse_xpos, mon_e.x);
        check("ypos", mouse_ypos, mon_e.y);
        check("left", left_mouse, mon_e.l);
        check("right", right_mouse, mon_e.r);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_xpos", mouse_xpos, 512);
    check("rst_ypos", mouse_ypos, 384);
    check("rst_left", left_mouse, 0);
    check("rst_right", right_mouse, 0);
    check("rst_pv", packet_valid, 0);
    check("rst_se", sync_error, 0);

    // Basic packet with explicit latency check on the last byte
    push_pkt(12'd528, 12'd379, 1'b0, 1'b0);
    send_byte(8'h08);
    send_byte(8'h10);
    @(posedge clk);
    #1;
    rx_data  = 8'h05;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("latency_pv_early", packet_valid, 0);
    @(negedge clk);
    check("latency_pv", packet_valid, 1);
    check("latency_xpos", mouse_xpos, 528);
    wait_drain("drain_basic");

    // Negative deltas and left button
    do_reset();
    push_pkt(12'd384, 12'd400, 1'b1, 1'b0);
    send_pkt(8'h39, 8'h80, 8'hF0);
    wait_drain("drain_neg");

    // Clamp high X, then clamp low Y
    do_reset();
    push_pkt(12'd767, 12'd384, 1'b0, 1'b0);
    send_pkt(8'h08, 8'hFF, 8'h00);
    push_pkt(12'd1000, 12'd384, 1'b0, 1'b0);
    send_pkt(8'h08, 8'hE9, 8'h00);
    push_pkt(12'd1023, 12'd384, 1'b0, 1'b0);
    send_pkt(8'h08, 8'h64, 8'h00);
    push_pkt(12'd1023, 12'd129, 1'b0, 1'b0);
    send_pkt(8'h08, 8'h00, 8'hFF);
    push_pkt(12'd1023, 12'd5, 1'b0, 1'b0);
    send_pkt(8'h08, 8'h00, 8'h7C);
    push_pkt(12'd1023, 12'd0, 1'b0, 1'b0);
    send_pkt(8'h08, 8'h00, 8'h14);
    wait_drain("drain_clamp");

    // X overflow suppresses dx only
    do_reset();
    push_pkt(12'd512, 12'd383, 1'b0, 1'b0);
    send_pkt(8'h48, 8'h7F, 8'h01);
    wait_drain("drain_ovf");

    // Misaligned first byte is dropped
    push_err();
    send_byte(8'h05);
    push_pkt(12'd514, 12'd383, 1'b0, 1'b0);
    send_pkt(8'h08, 8'h02, 8'h00);
    wait_drain("drain_misalign");

    // Inter-byte timeout discards the partial packet
    push_err();
    send_byte(8'h08);
    repeat (TimeoutCycles + 30) @(posedge clk);
    wait_drain("drain_timeout");
    push_pkt(12'd515, 12'd382, 1'b1, 1'b0);
    send_pkt(8'h09, 8'h01, 8'h01);
    push_pkt(12'd515, 12'd382, 1'b0, 1'b1);
    send_pkt(8'h0A, 8'h00, 8'h00);
    wait_drain("drain_after_timeout");

    // Asynchronous reset mid-packet
    send_byte(8'h08);
    send_byte(8'h10);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_xpos", mouse_xpos, 512);
    check("midrst_ypos", mouse_ypos, 384);
    check("midrst_right", right_mouse, 0);
    check("midrst_pv", packet_valid, 0);
    q.delete();
    m_x = 12'd512;
    m_y = 12'd384;
    m_l = 1'b0;
    m_r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    push_pkt(12'd528, 12'd379, 1'b0, 1'b0);
    send_pkt(8'h08, 8'h10, 8'h05);
    wait_drain("drain_after_midrst");

    repeat (5) @(posedge clk);
    check("queue_empty_end", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
